// File: rtl/ps2_kbd_wb_pkg.sv
// Shared definitions for the PS/2 keyboard Wishbone slave: register map,
// bit positions and the receive state encoding.
package kbd_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_OVF     = 9;
    localparam int ST_PERR    = 8;
    localparam int CTRL_INTEN = 0;
    localparam int CTRL_CLR   = 1;
    localparam int CTRL_FLUSH = 2;

    localparam logic [31:0] EMPTY_WORD = 32'h0000_0100;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

    // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic odd_ok(input logic [7:0] code, input logic par);
        return ^{code, par};
    endfunction

endpackage

// File: rtl/ps2_kbd_wb_if.sv
// Bus-side and receiver-side bundles for the keyboard slave.
interface kbd_wb_if;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic        int_o;

    modport master (output stb, we, addr, dat_i, input dat_o, ack, int_o);
    modport slave  (input stb, we, addr, dat_i, output dat_o, ack, int_o);
endinterface

interface kbd_rx_if;
    logic [7:0] code;
    logic       valid;
    logic       perr_pulse;

    modport master (output code, valid, perr_pulse);
    modport slave  (input code, valid, perr_pulse);
endinterface

// File: rtl/ps2_kbd_wb_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, frame FSM.
// Optional mid-frame inactivity abort enabled by macro KBD_TIMEOUT_EN.
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic     clk_25mhz,
    input  logic     RSTN,
    input  logic     ps2c,
    input  logic     ps2d,
    kbd_rx_if.master rx
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    // [0] metastable stage, [1] synced level, [2] previous synced level
    logic [2:0] c_sync_q, c_sync_d;
    logic [1:0] d_sync_q, d_sync_d;
    rx_state_e  state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       fall;
    logic       din;

    assign fall = c_sync_q[2] & ~c_sync_q[1];
    assign din  = d_sync_q[1];

`ifdef KBD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        c_sync_d  = {c_sync_q[1:0], ps2c};
        d_sync_d  = {d_sync_q[0], ps2d};
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        if (fall) begin
            unique case (state_q)
                IDLE: if (!din) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
                DATA: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = din;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (din) begin
                        valid_d = odd_ok(shift_q, par_q);
                        perr_d  = ~odd_ok(shift_q, par_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef KBD_TIMEOUT_EN
        to_cnt_d = (state_q == IDLE || fall) ? '0 : to_cnt_q + 1'b1;
        if (state_q != IDLE && !fall && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            state_d  = IDLE;
            shift_d  = '0;
            perr_d   = 1'b1;
            to_cnt_d = '0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_25mhz or negedge RSTN) begin
        if (!RSTN) begin
            c_sync_q  <= 3'b111;
            d_sync_q  <= 2'b11;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            c_sync_q  <= c_sync_d;
            d_sync_q  <= d_sync_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
        end
    end

`ifdef KBD_TIMEOUT_EN
    always_ff @(posedge clk_25mhz or negedge RSTN) begin
        if (!RSTN) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end
`endif

    assign rx.code       = shift_q;
    assign rx.valid      = valid_q;
    assign rx.perr_pulse = perr_q;

endmodule

// File: rtl/ps2_kbd_wb.sv
// PS/2 keyboard Wishbone slave: receiver, scan-code FIFO, DATA/STATUS/CTRL
// registers and level interrupt. Mid-frame timeout optional via KBD_TIMEOUT_EN.
module ps2_kbd_wb
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk_25mhz,
    input  logic        RSTN,
    input  logic        ps2c,
    input  logic        ps2d,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack,
    output logic        int_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, at least 2");
    end

    kbd_rx_if rx_if ();

    ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk_25mhz (clk_25mhz),
        .RSTN      (RSTN),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .rx        (rx_if)
    );

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d, perr_q, perr_d, int_en_q, int_en_d;
    logic        ack_q, ack_d, seen_q, seen_d, int_q, int_d;
    logic [31:0] dat_q, dat_d;
    logic        empty, full, access, pop, push, ctrl_wr;
    logic [AW:0] count_w;
    logic [31:0] count32, status;
    logic [7:0]  cnt8;
    logic        unused_bits;

    assign unused_bits = ^{addr[31:4], addr[1:0], dat_i[31:3]};

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_w = wr_ptr_q - rd_ptr_q;
    assign count32 = 32'(count_w);
    assign cnt8    = (count32 > 32'd255) ? 8'hFF : count32[7:0];

    always_comb begin
        status          = '0;
        status[ST_OVF]  = ovf_q;
        status[ST_PERR] = perr_q;
        status[7:0]     = cnt8;
    end

    // A held strobe is acked once; seen_q blocks re-entry until stb drops.
    assign access  = stb & ~ack_q & ~seen_q;
    assign pop     = access & ~we & (addr[3:2] == REG_DATA) & ~empty;
    assign push    = rx_if.valid & (~full | pop);
    assign ctrl_wr = access & we & (addr[3:2] == REG_CTRL);

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        ovf_d    = ovf_q;
        perr_d   = perr_q;
        int_en_d = int_en_q;
        ack_d    = access;
        seen_d   = stb & (seen_q | access);
        int_d    = int_en_q & ~empty;
        dat_d    = dat_q;
        if (ctrl_wr) begin
            int_en_d = dat_i[CTRL_INTEN];
            if (dat_i[CTRL_CLR]) begin
                ovf_d  = 1'b0;
                perr_d = 1'b0;
            end
            if (dat_i[CTRL_FLUSH]) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end
        end
        if (rx_if.valid && full && !pop) ovf_d = 1'b1;
        if (rx_if.perr_pulse) perr_d = 1'b1;
        if (access) begin
            dat_d = '0;
            if (!we) begin
                unique case (addr[3:2])
                    REG_DATA:   dat_d = empty ? EMPTY_WORD : {24'h0, mem_q[rd_ptr_q[AW-1:0]]};
                    REG_STATUS: dat_d = status;
                    REG_CTRL:   dat_d = {31'h0, int_en_q};
                    default:    dat_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_25mhz or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            int_en_q <= 1'b0;
            ack_q    <= 1'b0;
            seen_q   <= 1'b0;
            int_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
            int_en_q <= int_en_d;
            ack_q    <= ack_d;
            seen_q   <= seen_d;
            int_q    <= int_d;
            dat_q    <= dat_d;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_25mhz) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= rx_if.code;
    end

    assign dat_o = dat_q;
    assign ack   = ack_q;
    assign int_o = int_q;

endmodule

// File: tb/tb_ps2_kbd_wb.sv
// Scoreboard bench for ps2_kbd_wb: directed PS/2 frames and bus accesses,
// a monitor compares every ack against the queued expected read data.
module tb_ps2_kbd_wb;

    logic clk_25mhz = 1'b0;
    logic RSTN      = 1'b0;
    logic ps2c      = 1'b1;
    logic ps2d      = 1'b1;
    int   total     = 0;
    int   bad       = 0;

    typedef struct {
        bit          chk;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    kbd_wb_if bus ();

    always #20 clk_25mhz = ~clk_25mhz;

    ps2_kbd_wb #(.FIFO_DEPTH(16), .TIMEOUT_CYC(100)) dut (
        .clk_25mhz (clk_25mhz),
        .RSTN      (RSTN),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .stb       (bus.stb),
        .we        (bus.we),
        .addr      (bus.addr),
        .dat_i     (bus.dat_i),
        .dat_o     (bus.dat_o),
        .ack       (bus.ack),
        .int_o     (bus.int_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk_25mhz) begin
        exp_t e;
        if (RSTN && bus.ack) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", {31'h0, bus.ack}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                if (e.chk) check(e.name, bus.dat_o, e.val);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_25mhz);
        #2;
    endtask

    task automatic ps2_bit(input logic b);
        ps2d = b;
        tick(4);
        ps2c = 1'b0;
        tick(4);
        ps2c = 1'b1;
        tick(4);
    endtask

    task automatic send_frame(input logic [7:0] code, input bit good_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(good_par ? ~^code : ^code);
        ps2_bit(1'b1);
        tick(6);
    endtask

    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
                      input bit chk, input logic [31:0] expv, input string name,
                      output int acks, output logic int_at_ack);
        exp_t e;
        bit   got;
        int   n;
        e.chk = chk;
        e.val = expv;
        e.name = name;
        sb_q.push_back(e);
        tick(1);
        bus.stb = 1'b1;
        bus.we = w;
        bus.addr = a;
        bus.dat_i = d;
        got = 0;
        n = 0;
        acks = 0;
        int_at_ack = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk_25mhz);
            if (bus.ack) begin
                got = 1;
                acks++;
                int_at_ack = bus.int_o;
            end
            n++;
        end
        if (!got) check({name, "_ack"}, {31'h0, bus.ack}, 32'h1);
        repeat (hold) begin
            @(negedge clk_25mhz);
            if (bus.ack) acks++;
        end
        @(posedge clk_25mhz);
        #2;
        bus.stb = 1'b0;
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] expv, input string name);
        int   acks;
        logic ia;
        wb(1'b0, a, 32'h0, 0, 1'b1, expv, name, acks, ia);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int   acks;
        logic ia;
        wb(1'b1, a, d, 0, 1'b0, 32'h0, "write", acks, ia);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acks;
        logic ia;
        bus.stb = 1'b0;
        bus.we = 1'b0;
        bus.addr = '0;
        bus.dat_i = '0;
        #50;
        check("rst_ack", {31'h0, bus.ack}, 32'h0);
        check("rst_dat", bus.dat_o, 32'h0);
        check("rst_int", {31'h0, bus.int_o}, 32'h0);
        #13 RSTN = 1'b1;
        tick(3);

        // basic frame 0x1C
        send_frame(8'h1C, 1'b1);
        rd(32'h4, 32'h0000_0001, "status_one");
        rd(32'h0, 32'h0000_001C, "data_1c");
        rd(32'h4, 32'h0000_0000, "status_zero");

        // interrupt path
        wr(32'h8, 32'h1);
        check("int_idle", {31'h0, bus.int_o}, 32'h0);
        send_frame(8'h5A, 1'b1);
        check("int_rise", {31'h0, bus.int_o}, 32'h1);
        wb(1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h0000_005A, "data_5a", acks, ia);
        check("int_at_ack", {31'h0, ia}, 32'h1);
        check("int_fall", {31'h0, bus.int_o}, 32'h0);
        rd(32'h8, 32'h0000_0001, "ctrl_rd");
        wr(32'h8, 32'h0);

        // overflow: 17 frames into 16 entries
        for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 1'b1);
        rd(32'h4, 32'h0000_0210, "status_ovf");
        for (int i = 0; i < 16; i++) rd(32'h0, 32'h10 + 32'(i), "data_ovf_seq");
        rd(32'h4, 32'h0000_0200, "status_ovf_empty");
        wr(32'h8, 32'h2);
        rd(32'h4, 32'h0000_0000, "status_clr_ovf");

        // parity error
        send_frame(8'h1C, 1'b0);
        rd(32'h4, 32'h0000_0100, "status_perr");
        wr(32'h8, 32'h2);
        rd(32'h4, 32'h0000_0000, "status_clr_perr");

        // held strobe pops once
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wb(1'b0, 32'h0, 32'h0, 5, 1'b1, 32'h0000_0011, "data_hold", acks, ia);
        check("hold_acks", 32'(acks), 32'd1);
        rd(32'h4, 32'h0000_0001, "status_after_hold");
        rd(32'h0, 32'h0000_0022, "data_22");
        rd(32'h0, 32'h0000_0100, "data_empty");
        wr(32'hC, 32'hFFFF_FFFF);
        rd(32'hC, 32'h0000_0000, "reg3_rd");
        rd(32'h8, 32'h0000_0000, "ctrl_after_reg3");

        // flush
        send_frame(8'h77, 1'b1);
        wr(32'h8, 32'h4);
        rd(32'h4, 32'h0000_0000, "status_flush");

        // asynchronous reset mid-frame
        wr(32'h8, 32'h1);
        send_frame(8'h33, 1'b1);
        rd(32'h4, 32'h0000_0001, "status_pre_rst");
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2d = 1'b1;
        ps2c = 1'b0;
        tick(2);
        #5 RSTN = 1'b0;
        #1;
        check("arst_ack", {31'h0, bus.ack}, 32'h0);
        check("arst_dat", bus.dat_o, 32'h0);
        check("arst_int", {31'h0, bus.int_o}, 32'h0);
        ps2c = 1'b1;
        tick(3);
        #10 RSTN = 1'b1;
        tick(2);
        send_frame(8'h44, 1'b1);
        rd(32'h4, 32'h0000_0001, "status_post_rst");
        rd(32'h0, 32'h0000_0044, "data_post_rst");
        rd(32'h8, 32'h0000_0000, "ctrl_post_rst");

`ifdef KBD_TIMEOUT_EN
        // abandoned frame: start plus 4 data bits of 0x29, then silence
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        tick(150);
        rd(32'h4, 32'h0000_0100, "status_timeout");
        wr(32'h8, 32'h2);
        send_frame(8'h29, 1'b1);
        rd(32'h0, 32'h0000_0029, "data_29");
`endif

        tick(3);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_wb.md
Name: ps2_kbd_wb

Overview:
- Wishbone slave for the keyboard. Occupies slave slot 3 on the intercon and drives Keyboard_ACK, Keyboard_DAT_O and Keyboard_INT.
- Receives PS/2 frames from the raw PS2C/PS2D pins and checks parity.
- Buffers scan codes in a FIFO and presents data, status and control registers to the CPU.
- Asserts a level interrupt while data is pending and the interrupt is enabled.

Parameters:
- FIFO_DEPTH, 16: scan-code FIFO entries; must be a power of 2, minimum 2.
- TIMEOUT_CYC, 50000: clk_25mhz cycles of PS2C inactivity, mid-frame, before the frame is aborted (2 ms).

Ports:
- clk_25mhz  in  1  system clock; the only clock.
- RSTN  in  1  asynchronous active-low reset.
- ps2c  in  1  raw PS/2 clock pin (PS2C).
- ps2d  in  1  raw PS/2 data pin (PS2D).
- stb  in  1  Wishbone strobe (Keyboard_STB).
- we  in  1  write enable (slave_WE).
- addr  in  32  byte address (slave_ADDR); only addr[3:2] is decoded.
- dat_i  in  32  write data (slave_DAT_I).
- dat_o  out  32  read data (Keyboard_DAT_O).
- ack  out  1  acknowledge (Keyboard_ACK).
- int_o  out  1  interrupt (Keyboard_INT).

Behaviour:
- Reset:
  - Asynchronous on RSTN low. All state clears immediately, not on the next edge.
  - Outputs: dat_o=0, ack=0, int_o=0.
  - FIFO empty; error flags clear; int_en=0.
  - Receive FSM in IDLE. Synchronisers preset to 1 (idle bus level).
- Input sync:
  - ps2c and ps2d each pass through 2 flip-flops.
  - A falling edge is synced_c_prev=1 and synced_c=0.
  - Data is sampled on the falling-edge cycle.
- Receive FSM (sub-module), acting on falling edges only:
  - IDLE: data=0 -> DATA with bit count 0. data=1 (bad start) -> stay in IDLE.
  - DATA: shift bits LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: go to IDLE on every edge. Emit a 1-cycle valid pulse only if stop=1 and parity is odd over data+parity. Odd-parity failure sets PERR and emits nothing. Stop=0 also emits nothing.
  - Valid latency: asserted 1 cycle after the synced stop-bit edge.
- FIFO:
  - Circular buffer with pointers of log2(FIFO_DEPTH)+1 bits.
  - Full: MSBs differ and the low bits are equal. Empty: pointers equal.
  - Push when full: the byte is dropped, OVF is set, and contents are unchanged.
  - Simultaneous push and pop: both occur. This is legal even when full, and then the new byte is accepted.
- Register map (addr[3:2]):
  - 0 DATA (read-only):
    - Not empty: dat_o={24'h0, head}, and the FIFO pops in the ack cycle.
    - Empty: returns 32'h0000_0100 (bit 8 = empty) with no pop.
  - 1 STATUS (read-only): {22'h0, OVF[9], PERR[8], count[7:0]}. count saturates at 8 bits.
  - 2 CTRL:
    - Write: bit0 = int_en; bit1 = 1 clears OVF and PERR; bit2 = 1 flushes the FIFO.
    - Read: {31'h0, int_en}.
  - 3: reads 0; writes are ignored.
  - Writes to DATA or STATUS are ignored but still acked.
- Handshake:
  - ack is registered: ack <= stb & ~ack.
  - dat_o is registered in the same cycle as ack and holds until the next access.
  - Exactly one pop per strobe, even if stb is held high for several cycles; a new access needs stb to go low then high again.
- Interrupt: int_o = int_en & ~empty, registered; 1 cycle latency after the push or pop.
- CTRL flush in the same cycle as a push: the flush wins and the FIFO ends empty.

Optional Feature:
- Macro: KBD_TIMEOUT_EN.
- Defined:
  - A counter restarts on each falling edge while the FSM is not in IDLE.
  - Reaching TIMEOUT_CYC forces IDLE, discards partial bits and sets PERR. This resynchronises after a glitched or unplugged frame.
- Undefined:
  - No counter; the FSM waits indefinitely mid-frame.
  - TIMEOUT_CYC is unused.

Decomposition:
- Shared package kbd_pkg holds:
  - Register offsets: REG_DATA=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2.
  - STATUS bit positions: ST_OVF=9, ST_PERR=8.
  - CTRL bit positions: CTRL_INTEN=0, CTRL_CLR=1, CTRL_FLUSH=2.
  - Receive FSM state encoding: IDLE, DATA, PARITY, STOP.
- Sub-module ps2_rx contains the synchronisers, edge detect, FSM and optional timeout.
  - Outputs: code[7:0], valid, perr_pulse.
- The FIFO, register decode and ack logic stay in ps2_kbd_wb.

Test Plan:
- Send frame 0x1C with correct parity (bits 0,0,1,1,1,0,0,0, parity 0, stop 1), then read addr 0x0 -> STATUS count=1 before the read; the read returns 32'h1C; count=0 after.
- Write CTRL=1, then send 0x5A -> int_o rises within 4 cycles of the stop edge; reading DATA returns 0x5A and int_o falls 1 cycle after ack.
- Send 17 frames without reading (FIFO_DEPTH=16) -> STATUS=32'h0000_0210 (OVF=1, count=16); 16 DATA reads return the first 16 codes in order.
- Send 0x1C with parity bit 1 -> no push, STATUS=32'h100; write CTRL=2 -> STATUS=0.
- Hold stb high for 5 cycles on a DATA read with 2 entries queued -> a single ack pulse, one pop, count=1. Also assert RSTN low mid-frame -> all outputs 0 with no clock edge, and the next full frame is received correctly.
- With KBD_TIMEOUT_EN defined and TIMEOUT_CYC=100: stop after 4 data bits, idle 100 cycles -> PERR=1; then a full 0x29 frame is received correctly.
